// File: rtl/apu_envelope_length.sv
// One audio channel's volume envelope and length counter. They advance on the
// quarter-frame and half-frame pulses and drive a registered volume and active status.
module apu_envelope_length #(
   parameter int unsigned LEN_WIDTH = 8,
   parameter int unsigned DECAY_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable_240hz,
   input  logic       enable_120hz,
   input  logic       channel_en,
   input  logic       cfg_write,
   input  logic [5:0] cfg_data,
   input  logic       len_write,
   input  logic [4:0] len_index,
   output logic [3:0] volume,
   output logic       active
);

   localparam int unsigned CFG_W = 6;
   localparam int unsigned ENV_W = 4;

   logic [CFG_W-1:0]     cfg_q,    cfg_d;
   logic [LEN_WIDTH-1:0] length_q, length_d;
   logic [ENV_W-1:0]     decay_q,  decay_d;
   logic [ENV_W-1:0]     div_q,    div_d;
   logic                 start_q,  start_d;
   logic [ENV_W-1:0]     volume_d;
   logic                 active_d;

   logic             halt_loop;
   logic             const_vol;
   logic [ENV_W-1:0] period;

   assign halt_loop = cfg_q[5];
   assign const_vol = cfg_q[4];
   assign period    = cfg_q[3:0];

   function automatic logic [LEN_WIDTH-1:0] len_lookup(input logic [4:0] idx);
      logic [7:0] v;
      v = 8'd0;
      case (idx)
         5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
         5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
         5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
         5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
         5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
         5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
         5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
         5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;   5'd31: v = 8'd30;
      endcase
      return LEN_WIDTH'(v);
   endfunction

   // Next-state: frame steps always see the current (old) cfg register.
   always_comb begin
      cfg_d    = cfg_q;
      length_d = length_q;
      decay_d  = decay_q;
      div_d    = div_q;
      start_d  = start_q;

      if (cfg_write)
         cfg_d = cfg_data;

      if (!channel_en)
         length_d = '0;
      else if (len_write)
         length_d = len_lookup(len_index);
      else if (enable_120hz && (length_q != '0) && !halt_loop)
         length_d = length_q - LEN_WIDTH'(1);

      if (enable_240hz) begin
         if (start_q) begin
            start_d = 1'b0;
            decay_d = ENV_W'(DECAY_MAX);
            div_d   = period;
         end else if (div_q == '0) begin
            div_d = period;
            if (decay_q != '0)
               decay_d = decay_q - ENV_W'(1);
            else if (halt_loop)
               decay_d = ENV_W'(DECAY_MAX);
         end else begin
            div_d = div_q - ENV_W'(1);
         end
      end

      // A write landing on a quarter frame defers the restart to the next one.
      if (len_write)
         start_d = 1'b1;
   end

   // Outputs are derived from the current state, so they trail it by one clock.
   always_comb begin
      volume_d = '0;
      active_d = (length_q != '0);
      if (length_q != '0)
         volume_d = const_vol ? period : decay_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_q    <= '0;
         length_q <= '0;
         decay_q  <= '0;
         div_q    <= '0;
         start_q  <= 1'b0;
         volume   <= '0;
         active   <= 1'b0;
      end else begin
         cfg_q    <= cfg_d;
         length_q <= length_d;
         decay_q  <= decay_d;
         div_q    <= div_d;
         start_q  <= start_d;
         volume   <= volume_d;
         active   <= active_d;
      end
   end

endmodule
